// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with inter-frame gap and WAIT watchdog
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1048575,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [IW-1:0]             grant_id,
    output logic                      active,
    output logic [15:0]               frame_count,
    output logic                      timeout_err
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
    localparam state_t AFTER_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;
    state_t state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, win, idx;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic tx_start_q, tx_start_d, timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [19:0] wd_q, wd_d;
    logic [GW-1:0] gap_q, gap_d;
    // Scan from the lowest offset last so the first requester at or after rr_ptr wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req[idx]) win = idx;
        end
    end
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        frame_count_d = frame_count_q;
        timeout_err_d = timeout_err_q;
        wd_d          = '0;
        gap_d         = '0;
        case (state_q)
            IDLE: begin
                if (|req && !tx_busy) begin
                    state_d    = WAIT;
                    rr_ptr_d   = IW'((int'(win) + 1) % NUM_REQ);
                    ack_d      = NUM_REQ'(1) << win;
                    tx_start_d = 1'b1;
                    tx_data_d  = req_data[win*DATA_W +: DATA_W];
                    grant_id_d = win;
                end
            end
            WAIT: begin
                wd_d = wd_q + 20'd1;
                if (tx_done) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = AFTER_WAIT;
                    wd_d          = '0;
                end else if (wd_d == 20'(TIMEOUT_CYCLES)) begin
                    timeout_err_d = 1'b1;
                    state_d       = AFTER_WAIT;
                    wd_d          = '0;
                end
            end
            GAP: begin
                gap_d   = (gap_q == GW'(GAP_CYCLES - 1)) ? '0 : gap_q + GW'(1);
                state_d = (gap_q == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            frame_count_q <= frame_count_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
        end
    end
    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = (state_q != IDLE);
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench; second instance exercises a 50-cycle watchdog
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;
    logic [3:0] req, ack, req_w, ack_w;
    logic [31:0] req_data, req_data_w;
    logic tx_busy, tx_done, tx_start, active, timeout_err;
    logic tx_done_w, tx_start_w, active_w, timeout_err_w;
    logic [7:0] tx_data, tx_data_w;
    logic [1:0] grant_id, grant_id_w;
    logic [15:0] frame_count, frame_count_w;
    int checks = 0;
    int errors = 0;
    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;
    exp_t sb[$];

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .active(active), .frame_count(frame_count), .timeout_err(timeout_err)
    );
    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut_w (
        .clk(clk), .reset(reset), .req(req_w), .req_data(req_data_w), .ack(ack_w),
        .tx_start(tx_start_w), .tx_data(tx_data_w), .tx_busy(1'b0), .tx_done(tx_done_w),
        .grant_id(grant_id_w), .active(active_w), .frame_count(frame_count_w), .timeout_err(timeout_err_w)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        sb.push_back(e);
    endtask

    // Waits for tx_start, compares against the scoreboard head, then checks the pulse ends.
    task automatic take(input int lat);
        int n;
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < 200);
        chk("grant_latency", n, lat);
        chk("tx_start", tx_start, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant_id", grant_id, e.id);
            chk("tx_data", tx_data, e.data);
            chk("ack_onehot", ack, 4'b1 << e.id);
            chk("active", active, 1);
        end
        tick();
        chk("start_pulse", tx_start, 0);
        chk("ack_pulse", ack, 0);
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        req_w = '0; req_data_w = '0; tx_done_w = 1'b0;
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_active", active, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_err", timeout_err, 0);
        reset = 1'b0;

        // all four requesters held high
        req = 4'hF;
        req_data = 32'h13121110;
        for (int k = 0; k < 8; k++) push(2'(k % 4), 8'(8'h10 + k % 4));
        for (int k = 0; k < 8; k++) begin
            take(k == 0 ? 1 : 3);
            repeat (3) tick();
            chk("rr_data_stable", tx_data, 8'h10 + k % 4);
            done_pulse();
            if (k == 7) req = '0;
            chk("rr_fc", frame_count, k + 1);
        end
        repeat (2) tick();
        chk("rr_idle", active, 0);

        // single request, done 100 cycles after start
        req_data = 32'h005A0000;
        req = 4'b0100;
        push(2'd2, 8'h5A);
        take(1);
        req = '0;
        repeat (97) tick();
        chk("single_data_hold", tx_data, 8'h5A);
        done_pulse();
        chk("single_fc", frame_count, 9);
        chk("single_gap0", active, 1);
        tick();
        chk("single_gap1", active, 1);
        tick();
        chk("single_idle", active, 0);

        // busy transmitter holds off the grant
        tx_busy = 1'b1;
        req_data = 32'h00000077;
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("busy_no_start", tx_start, 0);
        end
        chk("busy_idle", active, 0);
        tx_busy = 1'b0;
        push(2'd0, 8'h77);
        take(1);
        req = '0;
        done_pulse();
        chk("busy_fc", frame_count, 10);
        repeat (2) tick();
        chk("busy_idle_after", active, 0);

        // wrap and spurious tx_done
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        tick();
        chk("preload_fc", frame_count, 16'hFFFF);
        done_pulse();
        chk("spurious_idle_fc", frame_count, 16'hFFFF);
        req_data = 32'h3C000000;
        req = 4'b1000;
        push(2'd3, 8'h3C);
        take(1);
        req = '0;
        done_pulse();
        chk("wrap_fc", frame_count, 0);
        done_pulse();
        chk("spurious_gap_fc", frame_count, 0);
        tick();
        chk("wrap_idle", active, 0);

        // reset during WAIT
        req_data = 32'hB300A100;
        req = 4'b0010;
        push(2'd1, 8'hA1);
        take(1);
        req = 4'b1010;
        tick();
        reset = 1'b1;
        tick();
        chk("wrst_ack", ack, 0);
        chk("wrst_start", tx_start, 0);
        chk("wrst_data", tx_data, 0);
        chk("wrst_grant", grant_id, 0);
        chk("wrst_active", active, 0);
        chk("wrst_fc", frame_count, 0);
        chk("wrst_err", timeout_err, 0);
        tick();
        chk("wrst_suppress_start", tx_start, 0);
        chk("wrst_suppress_ack", ack, 0);
        reset = 1'b0;
        push(2'd1, 8'hA1);
        take(1);
        req = 4'b1000;
        push(2'd3, 8'hB3);
        tick();
        done_pulse();
        chk("wrst_fc1", frame_count, 1);
        take(3);
        req = '0;
        done_pulse();
        chk("wrst_fc2", frame_count, 2);
        repeat (2) tick();
        chk("wrst_idle", active, 0);

        // watchdog instance: tx_done on the last allowed cycle wins over the timeout
        req_data_w = 32'h00000042;
        req_w = 4'b0001;
        tick();
        chk("wd_start1", tx_start_w, 1);
        chk("wd_grant1", grant_id_w, 0);
        chk("wd_data1", tx_data_w, 8'h42);
        req_w = '0;
        repeat (49) tick();
        chk("wd_err_before_done", timeout_err_w, 0);
        tx_done_w = 1'b1;
        tick();
        tx_done_w = 1'b0;
        chk("wd_tie_fc", frame_count_w, 1);
        chk("wd_tie_err", timeout_err_w, 0);
        chk("wd_tie_gap", active_w, 1);
        req_data_w = 32'h00002400;
        req_w = 4'b0010;
        tick();
        chk("wd_gap_ignores_req", tx_start_w, 0);
        tick();
        chk("wd_idle_no_start", tx_start_w, 0);
        tick();
        chk("wd_start2", tx_start_w, 1);
        chk("wd_grant2", grant_id_w, 1);
        chk("wd_data2", tx_data_w, 8'h24);
        req_w = '0;
        repeat (49) tick();
        chk("wd_err_49", timeout_err_w, 0);
        tick();
        chk("wd_err_50", timeout_err_w, 1);
        chk("wd_fc_unchanged", frame_count_w, 1);
        req_data_w = 32'h00660000;
        req_w = 4'b0100;
        repeat (3) tick();
        chk("wd_start3", tx_start_w, 1);
        chk("wd_grant3", grant_id_w, 2);
        chk("wd_data3", tx_data_w, 8'h66);
        chk("wd_err_sticky", timeout_err_w, 1);
        req_w = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among NUM_REQ byte sources. It sits between the requesting blocks and the UART transmitter's tx_start/data_in inputs. It launches one frame at a time, waits for frame completion, enforces an inter-frame gap and flags a hung transmitter with a watchdog. Its frame counter feeds the 7-segment display path for bring-up.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- DATA_W, 8: byte width.
- GAP_CYCLES, 2: idle cycles between tx_done and the next grant; 0 is legal.
- TIMEOUT_CYCLES, 1048575: WAIT-state watchdog limit, held in a 20-bit counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  level request; requester i has a byte pending.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i has been taken.
- tx_start  out  1  one-cycle pulse to the UART.
- tx_data  out  DATA_W  byte to the UART; stable from tx_start until leaving WAIT.
- tx_busy  in  1  UART transmitter busy.
- tx_done  in  1  one-cycle pulse at the end of a frame.
- grant_id  out  clog2(NUM_REQ)  index of the last or current owner.
- active  out  1  high in every state other than IDLE.
- frame_count  out  16  count of completed frames.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, WAIT, GAP.
- Pointer rr_ptr holds the highest-priority index. The search order is rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- IDLE: if any req is set and tx_busy=0, the following happen at the clock edge:
  - Select the winner w.
  - Latch tx_data = req_data[w], set grant_id = w, set rr_ptr = (w+1) mod NUM_REQ.
  - Drive ack[w]=1 and tx_start=1 for the next cycle only.
  - Go to WAIT.
- IDLE with tx_busy=1 stays in IDLE and grants nothing.
- WAIT: the watchdog counter increments every cycle from 0.
  - On tx_done=1: frame_count increments (wraps 0xFFFF→0x0000), then go to GAP, or to IDLE if GAP_CYCLES=0.
  - If the counter reaches TIMEOUT_CYCLES with no tx_done: set timeout_err=1, do not increment frame_count, go to GAP (or IDLE).
  - tx_done in the same cycle as the timeout takes priority: the frame counts, no error is flagged.
- GAP: counts GAP_CYCLES cycles, then goes to IDLE. req is ignored during GAP.
- tx_done received in IDLE or GAP is ignored; it does not count.
- Requester rule: a requester must drop req, or present its next byte, in the cycle after its ack. req is only sampled in IDLE, so there is at least one cycle of slack.
- A requester that drops req before it is granted loses its place. No state is held per requester.
- timeout_err clears only on reset.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0.
  - ack=0, tx_start=0, tx_data=0, grant_id=0, active=0, frame_count=0, timeout_err=0.
  - Watchdog and gap counters at 0.
- Reset asserted mid-frame: all of the above take effect at the next edge, and any pending ack or tx_start pulse is suppressed. The UART is reset separately.
- Latency from req to tx_start/ack is 1 cycle when IDLE and tx_busy=0.
- Grant-to-grant minimum is 1 (tx_start) + frame length up to tx_done + GAP_CYCLES + 1 cycles.
- With all requesters active, service order is 0,1,2,3,0,… Worst-case wait is NUM_REQ−1 frames.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single request: req=0b0100, req_data[2]=0x5A, UART done 100 cycles after start.
  - ack=0b0100 and tx_start pulse 1 cycle after req; tx_data=0x5A.
  - frame_count=1; IDLE again GAP_CYCLES+1 cycles after tx_done.
- All four requesters held high with bytes 0x10/0x11/0x12/0x13 for 8 frames.
  - grant_id sequence 0,1,2,3,0,1,2,3; tx_data matches each grant.
  - Exactly one ack bit per frame.
- tx_busy=1 while req=0b0001: no tx_start until tx_busy falls, then tx_start on the following cycle.
- Watchdog with TIMEOUT_CYCLES=50 and tx_done never asserted:
  - timeout_err=1 after 50 WAIT cycles; frame_count unchanged.
  - The next request is still granted, and timeout_err stays 1.
- Wrap and spurious pulses: preload 0xFFFF frames, or run with frame_count forced.
  - The next tx_done gives 0x0000.
  - A tx_done pulse in IDLE leaves frame_count unchanged.
- Reset in WAIT: all outputs return to reset values at the next edge and rr_ptr=0.
  - With req=0b1010 afterwards, requester 1 is granted first.
